load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the pipelined RV32I core. Consumes the decoded memory controls (write enable, access size, extension type) plus ALU-computed address and rs2 data, drives a word-wide request/grant/response data-memory bus, splits misaligned accesses into two word transactions, and returns sign/zero-extended load data. The pipeline stalls while the unit is busy.

## Interface
- ALLOW_MISALIGNED, 1, 1: split misaligned accesses; 0: complete them immediately with resp_err=1 and no bus traffic
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  memory-stage access present
- req_ready  out  1  unit idle; request accepted when req_valid&&req_ready
- req_write  in  1  1 store, 0 load (memwrite_en)
- req_size  in  2  00 byte, 01 half, 10 word, 11 none (data_size)
- req_unsigned  in  1  0 sign-extend, 1 zero-extend (extension_type); loads only
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores/none/error
- resp_err  out  1  misaligned access with ALLOW_MISALIGNED=0; valid with resp_valid
- busy  out  1  stall request to pipeline: state!=IDLE
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  write
- mem_addr  out  32  word address, bits[1:0]=00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid, at least one cycle after mem_gnt, in order
- mem_rdata  in  32  read word

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: req_ready=1. On accept, latch all req_* fields; off=addr[1:0]; misaligned = (half && off==3) || (word && off!=0).
- Accept transitions: size 11 -> DONE; misaligned && !ALLOW_MISALIGNED -> DONE with err; else REQ0.
- REQ0: mem_req=1, mem_addr={addr[31:2],00}, mem_be=(mask<<off)[3:0], mask 0001/0011/1111 by size; mem_wdata=wdata<<(8*off). On gnt: load -> WAIT0; store -> REQ1 if misaligned else DONE.
- WAIT0: on rvalid capture lo word; -> REQ1 if misaligned else DONE.
- REQ1: mem_addr=word address+4 (wraps 0xFFFFFFFC->0x00000000), mem_be=(mask<<off)[7:4], mem_wdata=wdata>>(8*(4-off)). On gnt: load -> WAIT1; store -> DONE.
- WAIT1: on rvalid capture hi word -> DONE.
- DONE: resp_valid=1, resp_rdata = extend(({hi,lo}>>(8*off)) truncated to size, req_unsigned); -> IDLE.
- mem_rvalid outside WAIT0/WAIT1 ignored; mem_gnt outside REQ0/REQ1 ignored.

## Timing
- All outputs registered. Reset values: req_ready=1, busy=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; state IDLE.
- Accept at edge N -> mem_req high from cycle N+1.
- Aligned store, gnt at N+1: resp_valid at N+2. Aligned load, gnt N+1, rvalid N+2: resp_valid N+3 (minimum).
- Misaligned adds one full request/grant (and response for loads) phase; second mem_req asserted the cycle after first gnt (store) or first rvalid (load).
- Size 11 or error: resp_valid at N+1, no mem_req.
- mem_req/addr/be/wdata/we stable while mem_req=1 and mem_gnt=0.
- Reset mid-operation: next edge all outputs to reset values, state IDLE; late rvalid dropped.
- New request accepted no earlier than the cycle after resp_valid (req_ready returns with IDLE).

## Structure
- Shared package core_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE), extension constants, lsu state enum.
- One sub-module lsu_align: combinational byte-enable/write-lane generation and load extraction/extension; FSM and registers stay in load_store_unit.

## Test plan
- SW addr 0x100 data 0xDEADBEEF, gnt immediate -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF, resp_valid 2 cycles after accept.
- LB addr 0x203, rdata word 0x80FFFFFF -> be 1000, resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
- LH addr 0x2, rdata 0x8001xxxx -> be 1100, resp_rdata 0xFFFF8001; LHU -> 0x00008001.
- Misaligned LW addr 0x101, words 0x44332211 @0x100 and 0x88776655 @0x104 -> be 1110 then 0001, resp_rdata 0x55443322; misaligned SW addr 0xFFFFFFFE -> second access addr 0x00000000, be 0011.
- ALLOW_MISALIGNED=0, LH addr 0x3 -> no mem_req, resp_valid next cycle, resp_err=1, rdata 0.
- Reset asserted during WAIT0, then rvalid -> all outputs reset values, no resp_valid; gnt delayed 3 cycles -> mem_req and fields held stable.

Source files
------------

// File: rtl/core_pkg.sv
// Shared load/store definitions: access-size encodings, extension modes and LSU FSM states.
package core_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StDone
  } lsu_state_e;

  // An access is misaligned when it spills into the following word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && (off == 2'd3)) || ((size == SZ_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and word-wide data-memory bus of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and write data for both word beats, and
// extraction plus sign/zero extension of load data from the {hi, lo} word pair.
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask;
  logic [7:0]  w_mask_sh;
  logic [63:0] w_wide;
  logic [31:0] w_raw;

  always_comb begin
    w_mask = 8'h00;
    unique case (i_size)
      SZ_BYTE: w_mask = 8'h01;
      SZ_HALF: w_mask = 8'h03;
      SZ_WORD: w_mask = 8'h0F;
      default: w_mask = 8'h00;
    endcase
  end

  // Shifting into a double-width window yields both beats at once.
  assign w_mask_sh = w_mask << i_off;
  assign w_wide    = {32'h0, i_wdata} << {i_off, 3'b000};
  assign w_raw     = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  assign o_be0    = w_mask_sh[3:0];
  assign o_be1    = w_mask_sh[7:4];
  assign o_wdata0 = w_wide[31:0];
  assign o_wdata1 = w_wide[63:32];

  always_comb begin
    o_rdata = 32'h0;
    unique case (i_size)
      SZ_BYTE: o_rdata = (i_unsigned == EXT_ZERO) ? {24'h0, w_raw[7:0]}
                                                 : {{24{w_raw[7]}}, w_raw[7:0]};
      SZ_HALF: o_rdata = (i_unsigned == EXT_ZERO) ? {16'h0, w_raw[15:0]}
                                                 : {{16{w_raw[15]}}, w_raw[15:0]};
      SZ_WORD: o_rdata = w_raw;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access at a time, misaligned accesses split into two
// word beats, every output registered from the next-state values.
module load_store_unit
  import core_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  load_store_unit_if.slave io_lsu
);

  lsu_state_e  r_state, w_state_n;
  logic        r_write, w_write_n;
  logic [1:0]  r_size, w_size_n;
  logic        r_unsigned, w_unsigned_n;
  logic [31:0] r_addr, w_addr_n;
  logic [31:0] r_wdata, w_wdata_n;
  logic        r_mis, w_mis_n;
  logic        r_err, w_err_n;
  logic [31:0] r_lo, w_lo_n;
  logic [31:0] r_hi, w_hi_n;

  logic        r_req_ready, r_busy, r_resp_valid, r_resp_err, r_mem_req, r_mem_we;
  logic [31:0] r_resp_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        w_resp_valid_n, w_resp_err_n, w_mem_req_n, w_mem_we_n;
  logic [31:0] w_resp_rdata_n, w_mem_addr_n, w_mem_wdata_n;
  logic [3:0]  w_mem_be_n;

  logic        w_accept;
  logic        w_mis_in;
  logic [31:0] w_word_n;
  logic [3:0]  w_be0, w_be1;
  logic [31:0] w_wdata0, w_wdata1, w_rdata;

  assign w_accept = (r_state == StIdle) && io_lsu.req_valid;
  assign w_mis_in = is_misaligned(io_lsu.req_size, io_lsu.req_addr[1:0]);

  // Fields as they will be held next cycle, so registered outputs line up with the state.
  assign w_write_n    = w_accept ? io_lsu.req_write    : r_write;
  assign w_size_n     = w_accept ? io_lsu.req_size     : r_size;
  assign w_unsigned_n = w_accept ? io_lsu.req_unsigned : r_unsigned;
  assign w_addr_n     = w_accept ? io_lsu.req_addr     : r_addr;
  assign w_wdata_n    = w_accept ? io_lsu.req_wdata    : r_wdata;
  assign w_mis_n      = w_accept ? w_mis_in            : r_mis;
  assign w_err_n      = w_accept ? (w_mis_in && !ALLOW_MISALIGNED) : r_err;
  assign w_lo_n = w_accept ? 32'h0 :
                  ((r_state == StWait0) && io_lsu.mem_rvalid) ? io_lsu.mem_rdata : r_lo;
  assign w_hi_n = w_accept ? 32'h0 :
                  ((r_state == StWait1) && io_lsu.mem_rvalid) ? io_lsu.mem_rdata : r_hi;
  assign w_word_n = {w_addr_n[31:2], 2'b00};

  lsu_align u_align (
    .i_size     (w_size_n),
    .i_off      (w_addr_n[1:0]),
    .i_unsigned (w_unsigned_n),
    .i_wdata    (w_wdata_n),
    .i_lo       (w_lo_n),
    .i_hi       (w_hi_n),
    .o_be0      (w_be0),
    .o_be1      (w_be1),
    .o_wdata0   (w_wdata0),
    .o_wdata1   (w_wdata1),
    .o_rdata    (w_rdata)
  );

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_lsu.req_valid) begin
          if (io_lsu.req_size == SZ_NONE)         w_state_n = StDone;
          else if (w_mis_in && !ALLOW_MISALIGNED) w_state_n = StDone;
          else                                    w_state_n = StReq0;
        end
      end
      StReq0: begin
        if (io_lsu.mem_gnt) begin
          if (!r_write)   w_state_n = StWait0;
          else if (r_mis) w_state_n = StReq1;
          else            w_state_n = StDone;
        end
      end
      StWait0: if (io_lsu.mem_rvalid) w_state_n = r_mis ? StReq1 : StDone;
      StReq1:  if (io_lsu.mem_gnt) w_state_n = r_write ? StDone : StWait1;
      StWait1: if (io_lsu.mem_rvalid) w_state_n = StDone;
      StDone:  w_state_n = StIdle;
      default: w_state_n = StIdle;
    endcase
  end

  always_comb begin
    w_mem_req_n    = 1'b0;
    w_mem_addr_n   = 32'h0;
    w_mem_be_n     = 4'h0;
    w_mem_wdata_n  = 32'h0;
    w_resp_valid_n = (w_state_n == StDone);
    w_resp_err_n   = w_resp_valid_n && w_err_n;
    w_resp_rdata_n = 32'h0;
    if (w_state_n == StReq0) begin
      w_mem_req_n   = 1'b1;
      w_mem_addr_n  = w_word_n;
      w_mem_be_n    = w_be0;
      w_mem_wdata_n = w_wdata0;
    end else if (w_state_n == StReq1) begin
      w_mem_req_n   = 1'b1;
      w_mem_addr_n  = w_word_n + 32'd4;
      w_mem_be_n    = w_be1;
      w_mem_wdata_n = w_wdata1;
    end
    w_mem_we_n = w_mem_req_n && w_write_n;
    if (w_resp_valid_n && !w_write_n && (w_size_n != SZ_NONE) && !w_err_n) begin
      w_resp_rdata_n = w_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_write      <= 1'b0;
      r_size       <= SZ_NONE;
      r_unsigned   <= EXT_SIGN;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_mis        <= 1'b0;
      r_err        <= 1'b0;
      r_lo         <= 32'h0;
      r_hi         <= 32'h0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_be     <= 4'h0;
      r_mem_wdata  <= 32'h0;
    end else begin
      r_state      <= w_state_n;
      r_write      <= w_write_n;
      r_size       <= w_size_n;
      r_unsigned   <= w_unsigned_n;
      r_addr       <= w_addr_n;
      r_wdata      <= w_wdata_n;
      r_mis        <= w_mis_n;
      r_err        <= w_err_n;
      r_lo         <= w_lo_n;
      r_hi         <= w_hi_n;
      r_req_ready  <= (w_state_n == StIdle);
      r_busy       <= (w_state_n != StIdle);
      r_resp_valid <= w_resp_valid_n;
      r_resp_rdata <= w_resp_rdata_n;
      r_resp_err   <= w_resp_err_n;
      r_mem_req    <= w_mem_req_n;
      r_mem_we     <= w_mem_we_n;
      r_mem_addr   <= w_mem_addr_n;
      r_mem_be     <= w_mem_be_n;
      r_mem_wdata  <= w_mem_wdata_n;
    end
  end

  assign io_lsu.req_ready  = r_req_ready;
  assign io_lsu.busy       = r_busy;
  assign io_lsu.resp_valid = r_resp_valid;
  assign io_lsu.resp_rdata = r_resp_rdata;
  assign io_lsu.resp_err   = r_resp_err;
  assign io_lsu.mem_req    = r_mem_req;
  assign io_lsu.mem_we     = r_mem_we;
  assign io_lsu.mem_addr   = r_mem_addr;
  assign io_lsu.mem_be     = r_mem_be;
  assign io_lsu.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: byte-level reference model predicts bus beats and responses; a memory
// responder with random grant/response delays serves the bus; a monitor compares.
module tb_load_store_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus0 ();
  load_store_unit_if bus1 ();

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_lsu(bus0));
  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_lsu(bus1));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gnt_mode = -1;
  int rv_mode = -1;
  bit fast = 1'b0;
  bit hold_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h80FF_FFFF;
      32'h0000_0000: return 32'h8001_1234;
      32'h0000_0100: return 32'h4433_2211;
      32'h0000_0104: return 32'h8877_6655;
      default:       return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk_reset(input string tag, input logic [9:0] flags, input logic [31:0] rd,
                           input logic [31:0] ad, input logic [31:0] wd);
    check({tag, " flags"}, {22'h0, flags}, 32'h0000_0200);
    check({tag, " resp_rdata"}, rd, 32'h0);
    check({tag, " mem_addr"}, ad, 32'h0);
    check({tag, " mem_wdata"}, wd, 32'h0);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus0.req_ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready timeout", {31'h0, bus0.req_ready}, 32'h1);
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, output int acc);
    wait_ready(60);
    bus0.req_valid    = 1'b1;
    bus0.req_write    = wr;
    bus0.req_size     = size;
    bus0.req_unsigned = uns;
    bus0.req_addr     = addr;
    bus0.req_wdata    = wdata;
    acc = cyc + 1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = $urandom;
    bus0.req_wdata = $urandom;
  endtask

  // Reference: walk the accessed bytes, group them by word, assemble and extend.
  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int nb, ntx, acc;
    logic [31:0] w0, a, val, b;
    logic [3:0] be0, be1;
    resp_t r;
    nb = nbytes(size);
    w0 = {addr[31:2], 2'b00};
    be0 = 4'h0; be1 = 4'h0; val = 32'h0;
    for (int i = 0; i < nb; i++) begin
      a = addr + 32'(i);
      if ({a[31:2], 2'b00} == w0) be0[a[1:0]] = 1'b1;
      else be1[a[1:0]] = 1'b1;
      b = mem_word({a[31:2], 2'b00}) >> (8 * a[1:0]);
      val = val | ((b & 32'hFF) << (8 * i));
    end
    if (!uns && nb > 0 && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8 * nb)) - 32'h1);
    ntx = (nb == 0) ? 0 : ((be1 != 4'h0) ? 2 : 1);
    if (ntx >= 1) exp_bus.push_back('{wr, w0, be0, wdata << (8 * addr[1:0])});
    if (ntx == 2) exp_bus.push_back('{wr, w0 + 32'd4, be1, wdata >> (8 * (4 - addr[1:0]))});
    r.rdata = (wr || nb == 0) ? 32'h0 : val;
    r.err = 1'b0;
    r.lat = !fast ? -1 : (ntx == 0 ? 0 : (wr ? ntx : 2 * ntx));
    drive_req(wr, size, uns, addr, wdata, acc);
    r.acc = acc;
    exp_resp.push_back(r);
    wait_ready(60);
  endtask

  // Memory responder: random or fixed grant/response delays plus ignorable stray pulses.
  initial begin
    int dly = 0, pend_cnt = 0;
    bit have_d = 0, pend = 0;
    logic [31:0] pend_data = 32'h0;
    bus0.mem_gnt = 1'b0; bus0.mem_rvalid = 1'b0; bus0.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus0.mem_gnt = 1'b0;
      bus0.mem_rvalid = 1'b0;
      bus0.mem_rdata = $urandom;
      if (pend && !hold_rv) begin
        if (pend_cnt == 0) begin
          bus0.mem_rvalid = 1'b1;
          bus0.mem_rdata = pend_data;
          pend = 0;
        end else pend_cnt--;
      end else if (!pend && (bus0.mem_req || !bus0.busy) && $urandom_range(0, 3) == 0) begin
        bus0.mem_rvalid = 1'b1;
      end
      if (bus0.mem_req) begin
        if (!have_d) begin
          dly = (gnt_mode < 0) ? int'($urandom_range(0, 3)) : gnt_mode;
          have_d = 1;
        end
        if (dly == 0) begin
          bus0.mem_gnt = 1'b1;
          have_d = 0;
          if (!bus0.mem_we) begin
            pend = 1;
            pend_cnt = (rv_mode < 0) ? int'($urandom_range(0, 2)) : rv_mode;
            pend_data = mem_word(bus0.mem_addr);
          end
        end else dly--;
      end else begin
        have_d = 0;
        if ($urandom_range(0, 7) == 0) bus0.mem_gnt = 1'b1;
      end
    end
  end

  // Monitor: bus beats, request stability while stalled, responses and latency.
  initial begin
    bus_t t, prev;
    resp_t r;
    bit prev_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wait = 0;
      end else begin
        if (prev_wait) begin
          check("stall mem_req", {31'h0, bus0.mem_req}, 32'h1);
          check("stall mem_addr", bus0.mem_addr, prev.addr);
          check("stall mem_be", {28'h0, bus0.mem_be}, {28'h0, prev.be});
          check("stall mem_wdata", bus0.mem_wdata, prev.wdata);
          check("stall mem_we", {31'h0, bus0.mem_we}, {31'h0, prev.we});
        end
        prev_wait = bus0.mem_req && !bus0.mem_gnt;
        prev = '{bus0.mem_we, bus0.mem_addr, bus0.mem_be, bus0.mem_wdata};
        if (bus0.mem_req && bus0.mem_gnt) begin
          if (exp_bus.size() == 0) begin
            check("unexpected bus beat", bus0.mem_addr, 32'hFFFF_FFFF);
          end else begin
            t = exp_bus.pop_front();
            check("mem_we", {31'h0, bus0.mem_we}, {31'h0, t.we});
            check("mem_addr", bus0.mem_addr, t.addr);
            check("mem_be", {28'h0, bus0.mem_be}, {28'h0, t.be});
            if (t.we) check("mem_wdata", bus0.mem_wdata, t.wdata);
          end
        end
        if (bus0.resp_valid) begin
          if (exp_resp.size() == 0) begin
            check("unexpected resp_valid", bus0.resp_rdata, 32'hFFFF_FFFF);
          end else begin
            r = exp_resp.pop_front();
            check("resp_rdata", bus0.resp_rdata, r.rdata);
            check("resp_err", {31'h0, bus0.resp_err}, {31'h0, r.err});
            if (r.lat >= 0) check("latency", 32'(cyc - r.acc), 32'(r.lat));
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  size;
    logic        wr;
    logic [31:0] addr;
    logic        err;
  } err_case_t;

  initial begin
    int acc;
    err_case_t ec[4];
    logic [31:0] a;
    ec[0] = '{SZ_HALF, 1'b0, 32'h3, 1'b1};
    ec[1] = '{SZ_WORD, 1'b0, 32'h402, 1'b1};
    ec[2] = '{SZ_WORD, 1'b1, 32'h101, 1'b1};
    ec[3] = '{SZ_NONE, 1'b0, 32'h7, 1'b0};
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = SZ_NONE;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = SZ_NONE;
    bus1.req_unsigned = 1'b0; bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
    bus1.mem_gnt = 1'b0; bus1.mem_rvalid = 1'b0; bus1.mem_rdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset dut0", {bus0.req_ready, bus0.busy, bus0.resp_valid, bus0.resp_err,
              bus0.mem_req, bus0.mem_we, bus0.mem_be}, bus0.resp_rdata, bus0.mem_addr,
              bus0.mem_wdata);
    chk_reset("reset dut1", {bus1.req_ready, bus1.busy, bus1.resp_valid, bus1.resp_err,
              bus1.mem_req, bus1.mem_we, bus1.mem_be}, bus1.resp_rdata, bus1.mem_addr,
              bus1.mem_wdata);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with zero-delay memory so exact latency is checked.
    fast = 1'b1; gnt_mode = 0; rv_mode = 0;
    issue(1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h0000_0203, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h0000_0203, 32'h0);
    issue(1'b0, SZ_HALF, 1'b0, 32'h0000_0002, 32'h0);
    issue(1'b0, SZ_HALF, 1'b1, 32'h0000_0002, 32'h0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0101, 32'h0);
    issue(1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678);
    issue(1'b0, SZ_NONE, 1'b0, 32'h0000_0040, 32'h0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h0000_0013, 32'hCAFE_F00D);

    // Grant held off for three cycles: request fields must stay put.
    fast = 1'b0; gnt_mode = 3; rv_mode = 1;
    issue(1'b1, SZ_HALF, 1'b0, 32'h0000_0033, 32'hA1B2_C3D4);
    issue(1'b0, SZ_WORD, 1'b1, 32'h0000_0102, 32'h0);

    // Reset while waiting for load data; the late rvalid must be dropped.
    gnt_mode = 0; hold_rv = 1'b1;
    exp_bus.push_back('{1'b0, 32'h0000_0100, 4'hF, 32'h0});
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, acc);
    @(posedge clk); #1;
    check("in WAIT0 busy", {31'h0, bus0.busy}, 32'h1);
    check("in WAIT0 mem_req", {31'h0, bus0.mem_req}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset("mid-op reset", {bus0.req_ready, bus0.busy, bus0.resp_valid, bus0.resp_err,
              bus0.mem_req, bus0.mem_we, bus0.mem_be}, bus0.resp_rdata, bus0.mem_addr,
              bus0.mem_wdata);
    rst_n = 1'b1;
    hold_rv = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("post-reset idle", {30'h0, bus0.resp_valid, bus0.req_ready}, 32'h1);
    end

    // Misalignment rejected when splitting is disabled.
    for (int i = 0; i < 4; i++) begin
      bus1.req_valid = 1'b1;
      bus1.req_write = ec[i].wr;
      bus1.req_size  = ec[i].size;
      bus1.req_addr  = ec[i].addr;
      bus1.req_wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      check("nomis resp_valid", {31'h0, bus1.resp_valid}, 32'h1);
      check("nomis resp_err", {31'h0, bus1.resp_err}, {31'h0, ec[i].err});
      check("nomis resp_rdata", bus1.resp_rdata, 32'h0);
      check("nomis mem_req", {31'h0, bus1.mem_req}, 32'h0);
      @(posedge clk); #1;
      check("nomis ready again", {30'h0, bus1.req_ready, bus1.resp_valid}, 32'h2);
    end

    // Randomized traffic against the reference model.
    gnt_mode = -1; rv_mode = -1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 32'h3FF));
        1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("bus queue drained", 32'(exp_bus.size()), 32'h0);
    check("resp queue drained", 32'(exp_resp.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
